// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb step controller with cop0 exception and interrupt entry.
// Define MC_PERF_CNT_EN to build the 32-bit instret/cycles performance counters.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [2:0]  ins_class,
  input  logic        mem_ready,
  input  logic        irq,
  input  logic        irq_en,
  output logic        imem_req,
  output logic        ir_wr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_wr_en,
  output logic        cop_wr_en,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        exc_req,
  output logic [1:0]  exc_code,
  output logic        retire,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    EXC    = 3'd6,
    BAD    = 3'd7
  } state_t;

  localparam logic [2:0] CL_ALU    = 3'd0;
  localparam logic [2:0] CL_LOAD   = 3'd1;
  localparam logic [2:0] CL_STORE  = 3'd2;
  localparam logic [2:0] CL_BRANCH = 3'd3;
  localparam logic [2:0] CL_JUMP   = 3'd4;
  localparam logic [2:0] CL_COP    = 3'd5;

  localparam logic [1:0] EC_ILLEGAL = 2'd1;
  localparam logic [1:0] EC_TIMEOUT = 2'd2;
  localparam logic [1:0] EC_IRQ     = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state_q;
  logic [2:0]      cls_q;
  logic [1:0]      exc_q;
  logic [TO_W-1:0] to_cnt;
  logic            timed_out;
  logic            take_irq;

  // A zero MEM_TIMEOUT never fires, so the counter is free to wrap while waiting.
  assign timed_out = (MEM_TIMEOUT != 0) && !mem_ready && (to_cnt == TO_LAST);
  assign take_irq  = irq & irq_en;
  assign state     = state_q;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      cls_q   <= '0;
      exc_q   <= '0;
      to_cnt  <= '0;
    end else begin
      to_cnt <= '0;
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (mem_ready) begin
            state_q <= DECODE;
          end else if (timed_out) begin
            state_q <= EXC;
            exc_q   <= EC_TIMEOUT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DECODE: begin
          cls_q <= ins_class;
          if (ins_class[2:1] == 2'b11) begin
            state_q <= EXC;
            exc_q   <= EC_ILLEGAL;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          case (cls_q)
            CL_ALU, CL_COP:    state_q <= WB;
            CL_LOAD, CL_STORE: state_q <= MEM;
            default: begin
              state_q <= take_irq ? EXC : FETCH;
              if (take_irq) exc_q <= EC_IRQ;
            end
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (cls_q == CL_STORE) begin
              state_q <= take_irq ? EXC : FETCH;
              if (take_irq) exc_q <= EC_IRQ;
            end else begin
              state_q <= WB;
            end
          end else if (timed_out) begin
            state_q <= EXC;
            exc_q   <= EC_TIMEOUT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WB: begin
          state_q <= take_irq ? EXC : FETCH;
          if (take_irq) exc_q <= EC_IRQ;
        end
        EXC:     state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode; only the handshake-completion strobes look at mem_ready.
  always_comb begin
    imem_req  = 1'b0;
    ir_wr     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_wr_en = 1'b0;
    cop_wr_en = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 2'd0;
    exc_req   = 1'b0;
    exc_code  = 2'd0;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_wr    = mem_ready;
      end
      EXEC: begin
        if (cls_q == CL_BRANCH || cls_q == CL_JUMP) begin
          pc_wr  = 1'b1;
          pc_src = 2'd1;
          retire = 1'b1;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        if (mem_ready && cls_q == CL_STORE) begin
          pc_wr  = 1'b1;
          retire = 1'b1;
        end
      end
      WB: begin
        reg_wr_en = (cls_q == CL_ALU) || (cls_q == CL_LOAD);
        cop_wr_en = (cls_q == CL_COP);
        pc_wr     = 1'b1;
        retire    = 1'b1;
      end
      EXC: begin
        exc_req  = 1'b1;
        pc_wr    = 1'b1;
        pc_src   = 2'd2;
        exc_code = exc_q;
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (retire) instret <= instret + 32'd1;
    end
  end
`else
  assign instret = '0;
  assign cycles  = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-instruction expected step lists built from the class rules.
// Build with +define+MC_PERF_CNT_EN to also check the performance counters against the model.
module tb_mc_sequencer;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_EXC = 3'd6;

  typedef struct packed {
    logic       imem_req;
    logic       ir_wr;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_wr_en;
    logic       cop_wr_en;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       exc_req;
    logic [1:0] exc_code;
    logic       retire;
    logic [2:0] state;
  } obs_t;

  logic        clk = 1'b0;
  logic        rest;
  logic [2:0]  ins_class;
  logic        mem_ready, irq, irq_en;
  logic        imem_req, ir_wr, dmem_req, dmem_we, reg_wr_en, cop_wr_en, pc_wr, exc_req, retire;
  logic [1:0]  pc_src, exc_code;
  logic [2:0]  state;
  logic [31:0] instret, cycles;
  obs_t        obs;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_cycles = 0;
  logic [31:0] m_instret = 0;

  always #5 clk = ~clk;

  mc_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(4)) dut (
    .clk(clk), .rest(rest), .ins_class(ins_class), .mem_ready(mem_ready), .irq(irq),
    .irq_en(irq_en), .imem_req(imem_req), .ir_wr(ir_wr), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_wr_en(reg_wr_en), .cop_wr_en(cop_wr_en), .pc_wr(pc_wr),
    .pc_src(pc_src), .exc_req(exc_req), .exc_code(exc_code), .retire(retire),
    .state(state), .instret(instret), .cycles(cycles)
  );

  assign obs = {imem_req, ir_wr, dmem_req, dmem_we, reg_wr_en, cop_wr_en, pc_wr,
                pc_src, exc_req, exc_code, retire, state};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rc();
    return 3'($urandom_range(0, 7));
  endfunction

  // Mostly short waits, occasionally right at or past the timeout boundary.
  function automatic int pickDelay();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 8) return r % 4;
    if (r == 8) return MEM_TIMEOUT - 1;
    if (r == 9) return MEM_TIMEOUT;
    return MEM_TIMEOUT + 2;
  endfunction

  task automatic checkNow(input obs_t e, input logic [63:0] ec, input string tag);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("[TB] FAIL %s: outputs observed %h expected %h", tag, obs, e);
    end
    vectors++;
    assert ({instret, cycles} === ec) else begin
      miscompares++;
      $error("[TB] FAIL %s_cnt: instret/cycles observed %h expected %h", tag, {instret, cycles}, ec);
    end
  endtask

  task automatic step(input logic rdy, input logic [2:0] cls_in, input logic irq_in,
                      input logic en_in, input obs_t e, input string tag);
    logic [63:0] ec;
    @(negedge clk);
    mem_ready = rdy;
    ins_class = cls_in;
    irq       = irq_in;
    irq_en    = en_in;
    #1;
`ifdef MC_PERF_CNT_EN
    ec = {m_instret, m_cycles};
`else
    ec = 64'd0;
`endif
    checkNow(e, ec, tag);
    if (e.retire) m_instret = m_instret + 32'd1;
    m_cycles = m_cycles + 32'd1;
  endtask

  task automatic excStep(input logic [1:0] code, input string tag);
    obs_t e;
    e = '0;
    e.state = ST_EXC; e.exc_req = 1'b1; e.pc_wr = 1'b1; e.pc_src = 2'd2; e.exc_code = code;
    step(rb(), rc(), rb(), rb(), e, tag);
  endtask

  task automatic applyReset();
    obs_t e;
    rest = 1'b0;
    mem_ready = rb(); ins_class = rc(); irq = rb(); irq_en = rb();
    #12;
    e = '0;
    checkNow(e, 64'd0, "reset");
    m_cycles  = 0;
    m_instret = 0;
    @(posedge clk);
    #1 rest = 1'b1;
    e = '0;
    e.state = ST_IDLE;
    step(rb(), rc(), rb(), rb(), e, "idle");
  endtask

  // One instruction from FETCH to its retire (or exception); abort_at>=0 resets mid-MEM.
  task automatic applyStimulus(input logic [2:0] cls, input int fdly, input int mdly,
                               input logic rirq, input logic ren, input int abort_at = -1);
    obs_t e;
    int   nwait;
    nwait = (fdly < MEM_TIMEOUT) ? fdly : MEM_TIMEOUT;
    for (int i = 0; i < nwait; i++) begin
      e = '0; e.state = ST_FETCH; e.imem_req = 1'b1;
      step(1'b0, rc(), rb(), rb(), e, "fetch_wait");
    end
    if (fdly >= MEM_TIMEOUT) begin
      excStep(2'd2, "exc_fetch_to");
      return;
    end
    e = '0; e.state = ST_FETCH; e.imem_req = 1'b1; e.ir_wr = 1'b1;
    step(1'b1, rc(), rb(), rb(), e, "fetch_ack");
    e = '0; e.state = ST_DECODE;
    step(rb(), cls, rb(), rb(), e, "decode");
    if (cls == 3'd6 || cls == 3'd7) begin
      excStep(2'd1, "exc_illegal");
      return;
    end
    e = '0; e.state = ST_EXEC;
    if (cls == 3'd3 || cls == 3'd4) begin
      e.pc_wr = 1'b1; e.pc_src = 2'd1; e.retire = 1'b1;
      step(rb(), rc(), rirq, ren, e, "exec_retire");
      if (rirq && ren) excStep(2'd3, "exc_irq");
      return;
    end
    step(rb(), rc(), rb(), rb(), e, "exec");
    if (cls == 3'd1 || cls == 3'd2) begin
      nwait = (mdly < MEM_TIMEOUT) ? mdly : MEM_TIMEOUT;
      for (int i = 0; i < nwait; i++) begin
        e = '0; e.state = ST_MEM; e.dmem_req = 1'b1; e.dmem_we = (cls == 3'd2);
        step(1'b0, rc(), rb(), rb(), e, "mem_wait");
        if (i == abort_at) begin
          #2 rest = 1'b0;
          #1;
          e = '0;
          checkNow(e, 64'd0, "mid_reset");
          #10;
          checkNow(e, 64'd0, "held_reset");
          m_cycles  = 0;
          m_instret = 0;
          @(posedge clk);
          #1 rest = 1'b1;
          e.state = ST_IDLE;
          step(rb(), rc(), rb(), rb(), e, "idle_after_abort");
          return;
        end
      end
      if (mdly >= MEM_TIMEOUT) begin
        excStep(2'd2, "exc_mem_to");
        return;
      end
      e = '0; e.state = ST_MEM; e.dmem_req = 1'b1; e.dmem_we = (cls == 3'd2);
      if (cls == 3'd2) begin
        e.pc_wr = 1'b1; e.retire = 1'b1;
        step(1'b1, rc(), rirq, ren, e, "mem_store");
        if (rirq && ren) excStep(2'd3, "exc_irq");
        return;
      end
      step(1'b1, rc(), rb(), rb(), e, "mem_load");
    end
    e = '0; e.state = ST_WB; e.pc_wr = 1'b1; e.retire = 1'b1;
    e.reg_wr_en = (cls == 3'd0 || cls == 3'd1);
    e.cop_wr_en = (cls == 3'd5);
    step(rb(), rc(), rirq, ren, e, "wb");
    if (rirq && ren) excStep(2'd3, "exc_irq");
  endtask

  initial begin
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(3'd0, 0, 0, 1'b0, 1'b0);
    applyStimulus(3'd1, 0, 3, 1'b0, 1'b1);
    applyStimulus(3'd2, 0, 0, 1'b1, 1'b0);
    applyStimulus(3'd3, 0, 0, 1'b0, 1'b0);
    applyStimulus(3'd4, 1, 0, 1'b1, 1'b1);
    applyStimulus(3'd5, 0, 0, 1'b0, 1'b0);
    applyStimulus(3'd0, 0, 0, 1'b1, 1'b1);
    applyStimulus(3'd0, 0, 0, 1'b1, 1'b0);
    applyStimulus(3'd7, 0, 0, 1'b0, 1'b0);
    applyStimulus(3'd6, 2, 0, 1'b0, 1'b0);
    applyStimulus(3'd0, MEM_TIMEOUT, 0, 1'b0, 1'b0);
    applyStimulus(3'd0, MEM_TIMEOUT - 1, 0, 1'b0, 1'b0);
    applyStimulus(3'd2, 0, MEM_TIMEOUT, 1'b0, 1'b0);
    applyStimulus(3'd1, 0, MEM_TIMEOUT - 1, 1'b1, 1'b1);
    for (int i = 0; i < 80; i++)
      applyStimulus(rc(), pickDelay(), pickDelay(), rb(), rb());
    applyStimulus(3'd1, 0, 5, 1'b0, 1'b0, 2);
    for (int i = 0; i < 20; i++)
      applyStimulus(rc(), pickDelay(), pickDelay(), rb(), rb());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
